// File: rtl/mio_arbiter_pkg.sv
// Shared types and constants for the two-master MIO bus arbiter.
// The optional BUSY watchdog is enabled by defining MIO_ARB_TIMEOUT_EN.
package mio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic MID_CPU = 1'b0;
  localparam logic MID_DMA = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mio_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory/MIO port.
// The arbiter uses the slave view; masters plus memory model use the master view.
interface mio_arb_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          m0_req,   m1_req;
  logic          m0_we,    m1_we;
  logic [AW-1:0] m0_addr,  m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt,   m1_gnt;
  logic          m0_done,  m1_done;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_req;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_rdata, mem_ready,
    output m0_gnt, m1_gnt, m0_done, m1_done, rdata, err,
    output mem_req, mem_w, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_rdata, mem_ready,
    input  m0_gnt, m1_gnt, m0_done, m1_done, rdata, err,
    input  mem_req, mem_w, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mio_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the master other than
// 'last' wins, a single requester always wins.
module mio_rr_pick
  import mio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    id    = MID_CPU;
    if (req == 2'b11) begin
      id = ~last;
    end else if (req[1]) begin
      id = MID_DMA;
    end
  end

endmodule

// File: rtl/mio_arbiter.sv
// Two-master memory bus arbiter with registered request/ready sequencing.
// Define MIO_ARB_TIMEOUT_EN to add the BUSY watchdog that aborts with err.
module mio_arbiter
  import mio_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int DW      = 32,
  parameter int AW      = 32
) (
  input logic     clk,
  input logic     reset,
  mio_arb_if.slave bus
);

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mio_arbiter: TIMEOUT must be within 2..255");
  end

  arb_state_e    state_q, state_d;
  logic          last_q,  last_d;
  logic          owner_q, owner_d;
  logic          we_q,    we_d;
  logic          err_q,   err_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick_valid, pick_id;
  logic          wdog_expired;

  mio_rr_pick u_pick (
    .req   ({bus.m1_req, bus.m0_req}),
    .last  (last_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

`ifdef MIO_ARB_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  // Zero outside BUSY, so the first BUSY cycle always starts from 0.
  always_comb begin
    wdog_d = 8'd0;
    if (state_q == BUSY) wdog_d = wdog_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wdog_q <= 8'd0;
    else       wdog_q <= wdog_d;
  end

  assign wdog_expired = (wdog_q == 8'(TIMEOUT - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          owner_d = pick_id;
          last_d  = pick_id;
          err_d   = 1'b0;
          we_d    = pick_id ? bus.m1_we    : bus.m0_we;
          addr_d  = pick_id ? bus.m1_addr  : bus.m0_addr;
          wdata_d = pick_id ? bus.m1_wdata : bus.m0_wdata;
        end
      end
      BUSY: begin
        // A ready on the expiry cycle still counts as a normal completion.
        if (bus.mem_ready) begin
          state_d = DONE;
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
        end else if (wdog_expired) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= MID_CPU;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.m0_gnt    = (state_q != IDLE) && (owner_q == MID_CPU);
  assign bus.m1_gnt    = (state_q != IDLE) && (owner_q == MID_DMA);
  assign bus.m0_done   = (state_q == DONE) && (owner_q == MID_CPU);
  assign bus.m1_done   = (state_q == DONE) && (owner_q == MID_DMA);
  assign bus.err       = (state_q == DONE) && err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_w     = (state_q == BUSY) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Self-checking bench for mio_arbiter: directed steps plus a randomized phase
// checked against a schedule model; honours MIO_ARB_TIMEOUT_EN.
module tb_mio_arbiter;

  localparam int TO = 16;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;
  int   last_m;
  logic [31:0] ta  [2];
  logic [31:0] twd [2];
  logic        twe [2];
  int          tws [2];
  bit          drop_early;

  mio_arb_if #(.DW(32), .AW(32)) bus ();

  mio_arbiter #(.TIMEOUT(TO), .DW(32), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic int eff_wait(input int w);
`ifdef MIO_ARB_TIMEOUT_EN
    return (w > TO - 1) ? TO - 1 : w;
`else
    return w;
`endif
  endfunction

  function automatic bit exp_abort(input int w);
`ifdef MIO_ARB_TIMEOUT_EN
    return w > TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock; then the memory model answers after tws[owner] BUSY cycles.
  task automatic tick();
    int own;
    @(posedge clk);
    #1;
    cyc++;
    own = bus.m1_gnt ? 1 : 0;
    if (bus.mem_req) begin
      bus.mem_ready = (busy_cnt == tws[own]);
      bus.mem_rdata = bus.mem_ready ? mem_fn(bus.mem_addr) : $urandom;
      busy_cnt++;
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      busy_cnt = 0;
    end
  endtask

  // pat bit k = master k requests; ta/twe/twd/tws hold each master's access.
  task automatic txn(input int pat);
    int first, second, own;
    int st[2], exp_done[2], act_done[2];
    bit rq[2], pend[2];
    logic [1:0] eg, gv;
    rq[0] = pat[0];
    rq[1] = pat[1];
    first  = (pat == 3) ? 1 - last_m : ((pat == 2) ? 1 : 0);
    second = 1 - first;
    st[first]       = cyc + 1;
    exp_done[first] = cyc + 2 + eff_wait(tws[first]);
    st[second] = 0;
    exp_done[second] = -1;
    if (pat == 3) begin
      st[second]       = exp_done[first] + 2;
      exp_done[second] = st[second] + 1 + eff_wait(tws[second]);
    end
    last_m = (pat == 3) ? second : first;
    bus.m0_we = twe[0]; bus.m0_addr = ta[0]; bus.m0_wdata = twd[0];
    bus.m1_we = twe[1]; bus.m1_addr = ta[1]; bus.m1_wdata = twd[1];
    bus.m0_req = rq[0];
    bus.m1_req = rq[1];
    act_done[0] = -1;
    act_done[1] = -1;
    pend = rq;
    for (int n = 0; n < 300 && (pend[0] || pend[1]); n++) begin
      tick();
      for (int k = 0; k < 2; k++)
        eg[k] = rq[k] && (cyc >= st[k]) && (cyc <= exp_done[k]);
      gv = {bus.m1_gnt, bus.m0_gnt};
      chk("gnt", gv, eg);
      if (bus.mem_req) begin
        own = bus.m1_gnt ? 1 : 0;
        chk("mem_addr", bus.mem_addr, ta[own]);
        chk("mem_w", bus.mem_w, twe[own]);
        chk("mem_wdata", bus.mem_wdata, twd[own]);
        // Later changes on the owner's inputs must be ignored.
        if (own == 0) begin
          bus.m0_addr = $urandom; bus.m0_wdata = $urandom;
          if (drop_early) bus.m0_req = 1'b0;
        end else begin
          bus.m1_addr = $urandom; bus.m1_wdata = $urandom;
          if (drop_early) bus.m1_req = 1'b0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if ((k == 0) ? bus.m0_done : bus.m1_done) begin
          if (!pend[k]) chk("extra_done", 1, 0);
          act_done[k] = cyc;
          pend[k] = 1'b0;
          chk("err", bus.err, exp_abort(tws[k]));
          if (exp_abort(tws[k])) chk("rdata_abort", bus.rdata, 32'h0);
          else if (!twe[k]) chk("rdata", bus.rdata, mem_fn(ta[k]));
          if (k == 0) bus.m0_req = 1'b0;
          else        bus.m1_req = 1'b0;
        end
      end
    end
    if (pend[0] || pend[1]) chk("txn_bound", {pend[1], pend[0]}, 2'b00);
    for (int k = 0; k < 2; k++)
      if (rq[k]) chk("done_cycle", act_done[k], exp_done[k]);
    tick();
  endtask

  initial begin
    drop_early = 1'b0;
    reset = 1'b1;
    bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
    tws[0] = 0; tws[1] = 0;
    tick();
    tick();
    chk("rst_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    chk("rst_done", {bus.m1_done, bus.m0_done}, 2'b00);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_w", bus.mem_w, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    last_m = 1;
    tick();

    // Tie from reset: m0 first, m1 three cycles later.
    ta[0] = 32'h0000_0040; twe[0] = 0; twd[0] = 32'h1111_1111; tws[0] = 0;
    ta[1] = 32'h0000_0080; twe[1] = 0; twd[1] = 32'h2222_2222; tws[1] = 0;
    txn(3);

    // Single CPU read.
    ta[0] = 32'h0000_0010; twe[0] = 0; tws[0] = 0;
    txn(1);
    chk("single_rdata", bus.rdata, 32'h1234_5678);

    // DMA write with four wait states.
    ta[1] = 32'h0000_0100; twe[1] = 1; twd[1] = 32'hCAFE_F00D; tws[1] = 4;
    txn(2);

    // Request dropped mid-BUSY; access still completes.
    drop_early = 1'b1;
    ta[0] = 32'h0000_0200; twe[0] = 0; tws[0] = 2;
    ta[1] = 32'h0000_0300; twe[1] = 1; twd[1] = 32'h0BAD_BEEF; tws[1] = 1;
    txn(3);
    drop_early = 1'b0;

    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 2; k++) begin
        ta[k]  = $urandom & 32'h0000_FFFC;
        twe[k] = 1'($urandom_range(0, 1));
        twd[k] = $urandom;
        tws[k] = $urandom_range(0, 3);
      end
      drop_early = 1'($urandom_range(0, 1));
      txn($urandom_range(1, 3));
    end
    drop_early = 1'b0;

    // Reset in BUSY: no done, then m0 wins the next tie.
    ta[0] = 32'h0000_0500; twe[0] = 0; tws[0] = 10;
    bus.m0_addr = ta[0]; bus.m0_we = 0; bus.m0_req = 1'b1;
    tick();
    tick();
    chk("pre_rst_gnt", bus.m0_gnt, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.m0_req = 1'b0;
    chk("rst_busy_mem_req", bus.mem_req, 1'b0);
    chk("rst_busy_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rst_busy_no_done", {bus.m1_done, bus.m0_done}, 2'b00);
    end
    last_m = 1;
    ta[0] = 32'h0000_0600; twe[0] = 0; tws[0] = 1;
    ta[1] = 32'h0000_0700; twe[1] = 0; tws[1] = 0;
    txn(3);

`ifdef MIO_ARB_TIMEOUT_EN
    // Memory never answers: abort with err and zero rdata.
    ta[0] = 32'h0000_0800; twe[0] = 0; tws[0] = 1000;
    txn(1);
`else
    // Memory never answers: BUSY holds indefinitely.
    begin
      int dones;
      dones = 0;
      ta[0] = 32'h0000_0800; tws[0] = 1000;
      bus.m0_addr = ta[0]; bus.m0_we = 0; bus.m0_req = 1'b1;
      for (int n = 0; n < 120; n++) begin
        tick();
        if (bus.m0_done || bus.m1_done) dones++;
      end
      chk("hang_mem_req", bus.mem_req, 1'b1);
      chk("hang_no_done", dones, 0);
      chk("hang_err", bus.err, 1'b0);
      reset = 1'b1;
      bus.m0_req = 1'b0;
      tick();
      reset = 1'b0;
      chk("hang_rst_mem_req", bus.mem_req, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
